branch_pred_ctrl: RTL and testbench
===================================

Name: branch_pred_ctrl

Overview:
- Parametrised successor to the controller's execute-stage branch decision logic.
- Adds a table of 2-bit saturating counters (BHT) that predicts conditional branches at fetch.
- Resolves all six RV32I branch conditions in execute and raises a redirect on mispredict or jump.
- Sits beside the controller: fetch reads a prediction, execute updates the table and drives PC redirect and flush.

Parameters:
- XLEN, 32, PC width.
- IDX_W, 6, BHT index width; table holds 2**IDX_W entries.
- CNT_W, 16, width of the branch and mispredict performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- PCF  in  XLEN  fetch PC
- PredTakenF  out  1  prediction for the instruction at PCF
- PCE  in  XLEN  PC of the instruction in execute
- BranchE  in  1  execute holds a conditional branch
- JumpE  in  1  execute holds jal/jalr
- funct3E  in  3  branch funct3
- ZEROE  in  1  ALU result zero
- LtE  in  1  signed less-than from datapath
- LtuE  in  1  unsigned less-than from datapath
- PredTakenE  in  1  PredTakenF carried down the pipeline
- StallE  in  1  execute stalled; no update, no redirect
- PCSrcE  out  1  branch/jump actually taken
- RedirectE  out  1  fetch must be redirected
- RedirSelE  out  1  1 = use target (branch/jump); 0 = use PCE+4
- FlushD  out  1  equals RedirectE
- FlushE  out  1  equals RedirectE
- BranchCnt  out  CNT_W  resolved branches
- MispredCnt  out  CNT_W  mispredicted branches

Behaviour:
- Index (fetch and execute): idx = PC[IDX_W+1:2].
- Read: combinational. PredTakenF = bht[idxF][1].
- Taken condition:
  - 000: ZEROE
  - 001: ~ZEROE
  - 100: LtE
  - 101: ~LtE
  - 110: LtuE
  - 111: ~LtuE
  - 010/011: not taken.
- TakenE = BranchE & cond.
- PCSrcE = TakenE | JumpE.
- Mispred = BranchE & (TakenE != PredTakenE).
- RedirectE = (JumpE | Mispred) & ~StallE.
- RedirSelE = PCSrcE.
- Update: on the clock edge, when BranchE & ~StallE, bht[idxE] moves toward TakenE and saturates at 00/11 (no wrap).
- Same cycle, same index for fetch read and execute write: fetch sees the pre-update value.
- Counters, updated when BranchE & ~StallE:
  - BranchCnt += 1
  - MispredCnt += Mispred
  - both wrap modulo 2**CNT_W.
- JumpE never updates the BHT or the counters.
- BranchE & JumpE together (illegal): jump wins for redirect; the BHT still updates.
- Reset:
  - every BHT entry = 01 (weakly not-taken)
  - counters = 0
  - GHR = 0
  - PredTakenF = 0
  - RedirectE, PCSrcE, FlushD, FlushE = 0 while reset is high, regardless of inputs.
  - Reset mid-operation discards any pending update.
- Latency: prediction 0 cycles; redirect 0 cycles (combinational in E); table update visible from the next cycle.

Optional Feature:
- Macro BRANCH_GSHARE_EN.
- Defined:
  - adds an IDX_W-bit global history register, shifted left with TakenE on each update.
  - index = PC[IDX_W+1:2] ^ GHR for both fetch and execute.
  - the execute index uses the GHR value captured at fetch, supplied on an extra input GhrE[IDX_W-1:0]; the fetch-time GHR is exported on GhrF.
  - on a mispredict, GHR is restored to {GhrE[IDX_W-2:0], TakenE}.
- Undefined: the ports and the GHR are absent; indexing is by PC only.

Decomposition:
- Package branch_pkg:
  - counter encoding constants SNT=00, WNT=01, WT=10, ST=11
  - funct3 branch codes BEQ/BNE/BLT/BGE/BLTU/BGEU
  - function sat_update(cnt, taken).
- One sub-module bht_table: the 2-bit array with one async read port, one sync write port, and synchronous reset init.

Test Plan:
- Reset, then PCF=0x40 → PredTakenF=0; BranchCnt=0.
- BEQ at PCE=0x40 with ZEROE=1, PredTakenE=0, taken twice (RedirectE=1, RedirSelE=1 each time) → entry 01→10→11; PCF=0x40 then gives PredTakenF=1.
- Entry at 11, BNE with ZEROE=1 → TakenE=0, Mispred=1, RedirSelE=0, entry becomes 10; MispredCnt increments.
- BLTU with LtuE=1, StallE=1 → RedirectE=0, no table or counter change. Deassert StallE → RedirectE=1 and the update occurs.
- JumpE=1, BranchE=0 → RedirectE=1, RedirSelE=1, FlushD=FlushE=1; counters unchanged.
- With BRANCH_GSHARE_EN: PCs 0x40 and 0x80 alias the same index (IDX_W=4). A taken history separates them; the test checks the indices differ and each entry trains independently.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: counter encodings, branch funct3 codes and helpers shared by
// the branch predictor controller and its history table.
`default_nettype none

package branch_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Two-bit saturating step; never wraps past strongly taken/not-taken.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == ST) ? ST : cnt + 2'd1;
        else
            return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

    function automatic logic branch_cond(input logic [2:0] funct3, input logic zero,
                                         input logic lt, input logic ltu);
        logic c;
        c = 1'b0;
        case (funct3)
            BEQ:     c = zero;
            BNE:     c = ~zero;
            BLT:     c = lt;
            BGE:     c = ~lt;
            BLTU:    c = ltu;
            BGEU:    c = ~ltu;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bht_table.sv
// bht_table: 2-bit counter array, async read port and a synchronous
// read-modify-write update port; every entry resets to weakly not-taken.
`default_nettype none

module bht_table
    import branch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0] mem [DEPTH];

    // Read returns the stored value, so a same-cycle update is not visible yet.
    assign rd_cnt = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= WNT;
        end else if (wr_en) begin
            mem[wr_idx] <= sat_update(mem[wr_idx], wr_taken);
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: fetch-time BHT prediction plus execute-time branch
// resolution, redirect and performance counters. Optional gshare: BRANCH_GSHARE_EN.
`default_nettype none

module branch_pred_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    input  logic [XLEN-1:0]  PCE,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic [2:0]       funct3E,
    input  logic             ZEROE,
    input  logic             LtE,
    input  logic             LtuE,
    input  logic             PredTakenE,
    input  logic             StallE,
`ifdef BRANCH_GSHARE_EN
    input  logic [IDX_W-1:0] GhrE,
    output logic [IDX_W-1:0] GhrF,
`endif
    output logic             PCSrcE,
    output logic             RedirectE,
    output logic             RedirSelE,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] MispredCnt
);

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic [1:0]       cnt_f;
    logic             taken_e;
    logic             mispred;
    logic             update;

    logic unused_pc;
    assign unused_pc = ^{PCF[XLEN-1:IDX_W+2], PCF[1:0], PCE[XLEN-1:IDX_W+2], PCE[1:0]};

    assign taken_e = BranchE & branch_cond(funct3E, ZEROE, LtE, LtuE);
    assign mispred = BranchE & (taken_e != PredTakenE);
    assign update  = BranchE & ~StallE & ~reset;

`ifdef BRANCH_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    assign idx_f = PCF[IDX_W+1:2] ^ ghr;
    assign idx_e = PCE[IDX_W+1:2] ^ GhrE;
    assign GhrF  = ghr;

    // A mispredict rebuilds history from the fetch-time snapshot, dropping
    // the wrong-path outcomes shifted in since.
    always_ff @(posedge clk) begin
        if (reset)
            ghr <= '0;
        else if (update)
            ghr <= mispred ? {GhrE[IDX_W-2:0], taken_e} : {ghr[IDX_W-2:0], taken_e};
    end
`else
    assign idx_f = PCF[IDX_W+1:2];
    assign idx_e = PCE[IDX_W+1:2];
`endif

    bht_table #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx_f),
        .rd_cnt   (cnt_f),
        .wr_en    (update),
        .wr_idx   (idx_e),
        .wr_taken (taken_e)
    );

    assign PredTakenF = cnt_f[1] & ~reset;
    assign PCSrcE     = (taken_e | JumpE) & ~reset;
    assign RedirectE  = (JumpE | mispred) & ~StallE & ~reset;
    assign RedirSelE  = PCSrcE;
    assign FlushD     = RedirectE;
    assign FlushE     = RedirectE;

    always_ff @(posedge clk) begin
        if (reset) begin
            BranchCnt  <= '0;
            MispredCnt <= '0;
        end else if (update) begin
            BranchCnt  <= BranchCnt + 1'b1;
            MispredCnt <= MispredCnt + {{(CNT_W-1){1'b0}}, mispred};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: vector table for branch resolution plus directed
// sequences for table training, stall, reset and counter wrap.
`default_nettype none

module tb_branch_pred_ctrl;
    import branch_pkg::*;

`ifdef BRANCH_GSHARE_EN
    localparam int IDX_W = 4;
`else
    localparam int IDX_W = 6;
`endif
    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset;
    logic [XLEN-1:0] PCF, PCE;
    logic PredTakenF, BranchE, JumpE, ZEROE, LtE, LtuE, PredTakenE, StallE;
    logic [2:0] funct3E;
    logic PCSrcE, RedirectE, RedirSelE, FlushD, FlushE;
    logic [CNT_W-1:0] BranchCnt, MispredCnt;
`ifdef BRANCH_GSHARE_EN
    logic [IDX_W-1:0] GhrE, GhrF;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    branch_pred_ctrl #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PCE(PCE),
        .BranchE(BranchE), .JumpE(JumpE), .funct3E(funct3E), .ZEROE(ZEROE),
        .LtE(LtE), .LtuE(LtuE), .PredTakenE(PredTakenE), .StallE(StallE),
`ifdef BRANCH_GSHARE_EN
        .GhrE(GhrE), .GhrF(GhrF),
`endif
        .PCSrcE(PCSrcE), .RedirectE(RedirectE), .RedirSelE(RedirSelE),
        .FlushD(FlushD), .FlushE(FlushE), .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
    );

    typedef struct {
        logic       br, jp;
        logic [2:0] f3;
        logic       z, lt, ltu, pt, st;
        logic       exp_pcsrc, exp_redir;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic br, input logic jp, input logic [2:0] f3, input logic z,
                            input logic lt, input logic ltu, input logic pt, input logic st);
        BranchE = br; JumpE = jp; funct3E = f3; ZEROE = z;
        LtE = lt; LtuE = ltu; PredTakenE = pt; StallE = st;
    endtask

    task automatic idle();
        drive_ex(1'b0, 1'b0, BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        //            br  jp  f3     z   lt  ltu pt  st  pcsrc redir
        vecs[0]  = '{1'b1,1'b0,BEQ,  1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1};
        vecs[1]  = '{1'b1,1'b0,BEQ,  1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,BNE,  1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0};
        vecs[3]  = '{1'b1,1'b0,BNE,  1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1};
        vecs[4]  = '{1'b1,1'b0,BLT,  1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0};
        vecs[5]  = '{1'b1,1'b0,BGE,  1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,BGE,  1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1};
        vecs[7]  = '{1'b1,1'b0,BLTU, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1};
        vecs[8]  = '{1'b1,1'b0,BGEU, 1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1};
        vecs[9]  = '{1'b1,1'b0,3'b010,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,3'b011,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1};
        vecs[11] = '{1'b0,1'b1,BEQ,  1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1};
        vecs[12] = '{1'b0,1'b0,BEQ,  1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,BEQ,  1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0};
        vecs[14] = '{1'b0,1'b1,BEQ,  1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0};
        vecs[15] = '{1'b1,1'b1,BEQ,  1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1};

        PCF = 32'h40; PCE = 32'h100;
`ifdef BRANCH_GSHARE_EN
        GhrE = '0;
`endif
        reset = 1'b1;
        drive_ex(1'b0, 1'b1, BEQ, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("reset_redirect", RedirectE, 0);
        check("reset_pcsrc", PCSrcE, 0);
        check("reset_flushd", FlushD, 0);
        tick();
        reset = 1'b0;
        idle();
        check("reset_predf", PredTakenF, 0);
        check("reset_branchcnt", BranchCnt, 0);
        check("reset_mispredcnt", MispredCnt, 0);

        // Resolution table; the entry at 0x100 and the counters take the updates.
        for (int i = 0; i < 16; i++) begin
            drive_ex(vecs[i].br, vecs[i].jp, vecs[i].f3, vecs[i].z,
                     vecs[i].lt, vecs[i].ltu, vecs[i].pt, vecs[i].st);
            #1;
            check($sformatf("vec%0d_pcsrc", i), PCSrcE, vecs[i].exp_pcsrc);
            check($sformatf("vec%0d_redirsel", i), RedirSelE, vecs[i].exp_pcsrc);
            check($sformatf("vec%0d_redirect", i), RedirectE, vecs[i].exp_redir);
            check($sformatf("vec%0d_flushe", i), FlushE, vecs[i].exp_redir);
            tick();
        end
        idle();
        check("vec_branchcnt", BranchCnt, 12);
        check("vec_mispredcnt", MispredCnt, 6);

        // Training at 0x40
        do_reset();
        PCF = 32'h40; PCE = 32'h40;
        drive_ex(1'b1, 1'b0, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("beq1_redirect", RedirectE, 1);
        check("beq1_redirsel", RedirSelE, 1);
        check("beq1_predf_preupdate", PredTakenF, 0);
        tick();
        check("beq1_predf_after", PredTakenF, 1);
        check("beq2_redirect", RedirectE, 1);
        check("beq2_redirsel", RedirSelE, 1);
        tick();
        idle();
        check("beq2_predf", PredTakenF, 1);
        check("beq2_branchcnt", BranchCnt, 2);
        check("beq2_mispredcnt", MispredCnt, 2);

        drive_ex(1'b1, 1'b0, BNE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("bne_pcsrc", PCSrcE, 0);
        check("bne_redirect", RedirectE, 1);
        check("bne_redirsel", RedirSelE, 0);
        tick();
        idle();
        check("bne_predf", PredTakenF, 1);
        check("bne_mispredcnt", MispredCnt, 3);
        drive_ex(1'b1, 1'b0, BNE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        check("bne2_predf", PredTakenF, 0);
        check("bne2_branchcnt", BranchCnt, 4);

        drive_ex(1'b1, 1'b0, BLTU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        check("stall_redirect", RedirectE, 0);
        check("stall_pcsrc", PCSrcE, 1);
        tick();
        check("stall_branchcnt", BranchCnt, 4);
        check("stall_predf", PredTakenF, 0);
        StallE = 1'b0;
        #1;
        check("unstall_redirect", RedirectE, 1);
        tick();
        idle();
        check("unstall_predf", PredTakenF, 1);
        check("unstall_branchcnt", BranchCnt, 5);
        check("unstall_mispredcnt", MispredCnt, 5);

        drive_ex(1'b0, 1'b1, BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("jump_redirect", RedirectE, 1);
        check("jump_redirsel", RedirSelE, 1);
        check("jump_flushd", FlushD, 1);
        check("jump_flushe", FlushE, 1);
        tick();
        idle();
        check("jump_branchcnt", BranchCnt, 5);
        check("jump_mispredcnt", MispredCnt, 5);

        // Saturation at strongly not-taken must not wrap
        PCF = 32'h44; PCE = 32'h44;
        drive_ex(1'b1, 1'b0, BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        idle();
        check("sat_low_predf", PredTakenF, 0);
        drive_ex(1'b1, 1'b0, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("sat_step1_predf", PredTakenF, 0);
        drive_ex(1'b1, 1'b0, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("sat_step2_predf", PredTakenF, 1);
        check("sat_branchcnt", BranchCnt, 10);
        check("sat_mispredcnt", MispredCnt, 7);

        // Reset together with a valid update discards it
        drive_ex(1'b1, 1'b0, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midreset_pcsrc", PCSrcE, 0);
        tick();
        reset = 1'b0;
        idle();
        check("midreset_branchcnt", BranchCnt, 0);
        check("midreset_predf", PredTakenF, 0);

`ifdef BRANCH_GSHARE_EN
        PCE = 32'h40; GhrE = '0;
        drive_ex(1'b1, 1'b0, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("gs_ghr1", GhrF, 1);
        PCF = 32'h80;
        #1;
        check("gs_alias_split_predf", PredTakenF, 0);
        PCF = 32'h44;
        #1;
        check("gs_trained_entry_predf", PredTakenF, 1);
        PCE = 32'h80; GhrE = 4'd1;
        drive_ex(1'b1, 1'b0, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("gs_ghr2", GhrF, 3);
        do_reset();
        GhrE = '0;
`endif

        // Counter wrap: every branch mispredicts
        PCE = 32'h48;
        drive_ex(1'b1, 1'b0, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (65535) tick();
        idle();
        check("wrap_branchcnt_max", BranchCnt, 16'hFFFF);
        check("wrap_mispredcnt_max", MispredCnt, 16'hFFFF);
        drive_ex(1'b1, 1'b0, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("wrap_branchcnt_zero", BranchCnt, 0);
        check("wrap_mispredcnt_zero", MispredCnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
